// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Defaults assume a 100 MHz clock: 10 ms debounce window, 1 s long-press.
package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } btn_state_e;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned LONG_CYCLES_DEF     = 100_000_000;

   // Width holding 0..n-1; a count of 1 still needs one bit of storage.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into clk.
// Both stages clear to 0 under synchronous active-low reset.
module sync_2ff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes a raw button, accepts edges after a
// stable window, and emits press/release/long-press pulses and a press count.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       btn,
   output logic       btn_level,
   output logic       btn_press,
   output logic       btn_release,
   output logic       btn_long,
   output logic [3:0] press_cnt
);

   localparam int unsigned   DW        = cnt_w(DEBOUNCE_CYCLES);
   localparam int unsigned   LW        = cnt_w(LONG_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic          LONG_NOW  = (LONG_CYCLES == 1);

   logic          btn_sync;
   btn_state_e    state_q;
   logic [DW-1:0] deb_cnt_q;
   logic [DW-1:0] deb_cnt_d;
   logic [LW-1:0] long_cnt_q;
   logic [LW-1:0] long_cnt_d;
   logic          long_done_q;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic          long_q;
   logic [3:0]    press_cnt_q;
   logic          rel_accept;
   logic          long_step;
   logic          long_hit;

   sync_2ff #(.W(1)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (btn),
      .q      (btn_sync)
   );

   // The hold timer stops on the cycle a release is accepted so that a
   // long-press and a release can never pulse together.
   always_comb begin
      deb_cnt_d  = deb_cnt_q + DW'(1);
      long_cnt_d = long_cnt_q + LW'(1);
      rel_accept = (state_q == RELEASE_CHK) && !btn_sync && (deb_cnt_q == DEB_LAST);
      long_step  = ((state_q == PRESSED) || (state_q == RELEASE_CHK)) && !rel_accept &&
                   (long_cnt_q != LONG_LAST);
      long_hit   = long_step && (long_cnt_d == LONG_LAST) && !long_done_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= RELEASED;
         deb_cnt_q   <= '0;
         long_cnt_q  <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= long_hit;

         if (long_step) long_cnt_q <= long_cnt_d;
         if (long_hit)  long_done_q <= 1'b1;

         unique case (state_q)
            RELEASED: begin
               if (btn_sync) begin
                  state_q   <= PRESS_CHK;
                  deb_cnt_q <= '0;
               end
            end
            PRESS_CHK: begin
               if (!btn_sync) begin
                  state_q <= RELEASED;
               end else if (deb_cnt_q == DEB_LAST) begin
                  state_q     <= PRESSED;
                  level_q     <= 1'b1;
                  press_q     <= 1'b1;
                  press_cnt_q <= press_cnt_q + 4'd1;
                  long_cnt_q  <= '0;
                  long_done_q <= LONG_NOW;
                  long_q      <= LONG_NOW;
               end else begin
                  deb_cnt_q <= deb_cnt_d;
               end
            end
            PRESSED: begin
               if (!btn_sync) begin
                  state_q   <= RELEASE_CHK;
                  deb_cnt_q <= '0;
               end
            end
            RELEASE_CHK: begin
               if (btn_sync) begin
                  state_q <= PRESSED;
               end else if (rel_accept) begin
                  state_q   <= RELEASED;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_d;
               end
            end
            default: state_q <= RELEASED;
         endcase
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_long    = long_q;
   assign press_cnt   = press_cnt_q;

endmodule
